// File: rtl/vga_strip_scanner.sv
// vga_strip_scanner: VGA timing and address generator for a dual-bank strip
// framebuffer. The beam reads one bank while the renderer fills the other one
// strip ahead. Sync, blanking and pixel data leave through a delay line that
// absorbs the BRAM read latency.
module vga_strip_scanner #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int STRIP_LINES = 32,
  parameter int PIX_W       = 12,
  parameter int POS_W       = 10,
  parameter int ADDR_W      = 15,
  parameter int RD_LATENCY  = 1,
  parameter int SYNC_POL    = 0
) (
  input  logic              clk25M,
  input  logic              reset,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bank,
  input  logic [PIX_W-1:0]  rd_data_a,
  input  logic [PIX_W-1:0]  rd_data_b,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [POS_W-1:0]  wr_hpos,
  output logic [POS_W-1:0]  wr_vpos,
  output logic [PIX_W-1:0]  rgb,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              line_tick,
  output logic              frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SL_W    = (STRIP_LINES > 1) ? $clog2(STRIP_LINES) : 1;

  localparam logic [POS_W-1:0]  H_LAST    = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0]  V_LAST    = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0]  H_ACT     = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0]  V_ACT     = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0]  HS_ON     = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0]  HS_OFF    = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0]  VS_ON     = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0]  VS_OFF    = POS_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [POS_W-1:0]  NORM_END  = POS_W'(V_ACTIVE - STRIP_LINES);
  localparam logic [POS_W-1:0]  PRE_START = POS_W'(V_TOTAL - STRIP_LINES);
  localparam logic [POS_W-1:0]  SL_P      = POS_W'(STRIP_LINES);
  localparam logic [SL_W-1:0]   SL_LAST   = SL_W'(STRIP_LINES - 1);
  localparam logic [ADDR_W-1:0] H_ACT_A   = ADDR_W'(H_ACTIVE);
  localparam logic              SYNC_ON   = 1'(SYNC_POL);

  // Parameter sanity: bad geometry stops elaboration.
  if (V_ACTIVE % STRIP_LINES != 0) begin : g_err_strip_div
    $error("vga_strip_scanner: V_ACTIVE must be a multiple of STRIP_LINES");
  end
  if (V_TOTAL - V_ACTIVE < STRIP_LINES) begin : g_err_vblank
    $error("vga_strip_scanner: vertical blanking shorter than one strip");
  end
  if ((longint'(1) << ADDR_W) < longint'(STRIP_LINES) * longint'(H_ACTIVE)) begin : g_err_addr
    $error("vga_strip_scanner: ADDR_W too small for one strip");
  end
  if (RD_LATENCY < 1) begin : g_err_lat
    $error("vga_strip_scanner: RD_LATENCY must be at least 1");
  end

  logic [POS_W-1:0] hpos_q, hpos_d;
  logic [POS_W-1:0] vpos_q, vpos_d;
  logic [SL_W-1:0]  sline_q, sline_d;
  logic [POS_W-1:0] strip_q, strip_d;
  logic             rd_bank_hold_q;

  logic             active, h_vis, win_norm, win_pre, hs_act, vs_act;
  logic [POS_W-1:0] pre_line;
  logic [ADDR_W-1:0] line_addr, pre_addr;

  logic [RD_LATENCY-1:0] de_pipe_q, bank_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [PIX_W-1:0] rgb_q;
  logic             de_q, hsync_q, vsync_q;

  // Next-state for the beam counters; sline/strip step with vpos, no divider.
  always_comb begin
    hpos_d  = hpos_q + POS_W'(1);
    vpos_d  = vpos_q;
    sline_d = sline_q;
    strip_d = strip_q;
    if (hpos_q == H_LAST) begin
      hpos_d = '0;
      if (vpos_q == V_LAST) begin
        vpos_d  = '0;
        sline_d = '0;
        strip_d = '0;
      end else begin
        vpos_d = vpos_q + POS_W'(1);
        if (sline_q == SL_LAST) begin
          sline_d = '0;
          strip_d = strip_q + POS_W'(1);
        end else begin
          sline_d = sline_q + SL_W'(1);
        end
      end
    end
  end

  // Beam counter and displayed-bank hold registers.
  always_ff @(posedge clk25M) begin
    if (reset) begin
      hpos_q         <= '0;
      vpos_q         <= '0;
      sline_q        <= '0;
      strip_q        <= '0;
      rd_bank_hold_q <= 1'b0;
    end else begin
      hpos_q         <= hpos_d;
      vpos_q         <= vpos_d;
      sline_q        <= sline_d;
      strip_q        <= strip_d;
      rd_bank_hold_q <= rd_bank;
    end
  end

  // Region decode and address arithmetic shared by the read and write sides.
  always_comb begin
    h_vis     = hpos_q < H_ACT;
    active    = h_vis && (vpos_q < V_ACT);
    win_norm  = h_vis && (vpos_q < NORM_END);
    win_pre   = h_vis && (vpos_q >= PRE_START);
    hs_act    = (hpos_q >= HS_ON) && (hpos_q < HS_OFF);
    vs_act    = (vpos_q >= VS_ON) && (vpos_q < VS_OFF);
    pre_line  = vpos_q - PRE_START;
    line_addr = ADDR_W'(sline_q) * H_ACT_A + ADDR_W'(hpos_q);
    pre_addr  = ADDR_W'(pre_line) * H_ACT_A + ADDR_W'(hpos_q);
  end

  // Read side: the bank only changes on visible pixels, so it holds in blanking.
  always_comb begin
    rd_addr = '0;
    rd_bank = rd_bank_hold_q;
    if (reset) begin
      rd_bank = 1'b0;
    end else if (active) begin
      rd_addr = line_addr;
      rd_bank = strip_q[0];
    end
  end

  // Write window: one strip ahead of the beam, or strip 0 during vblank.
  always_comb begin
    wr_en   = 1'b0;
    wr_bank = ~rd_bank;
    wr_addr = '0;
    wr_hpos = '0;
    wr_vpos = '0;
    if (!reset) begin
      if (win_norm) begin
        wr_en   = 1'b1;
        wr_bank = ~strip_q[0];
        wr_addr = line_addr;
        wr_hpos = hpos_q;
        wr_vpos = vpos_q + SL_P;
      end else if (win_pre) begin
        wr_en   = 1'b1;
        wr_bank = 1'b0;
        wr_addr = pre_addr;
        wr_hpos = hpos_q;
        wr_vpos = pre_line;
      end
    end
  end

  // Line and frame pulses decoded straight from the counters.
  always_comb begin
    line_tick  = !reset && (hpos_q == H_ACT);
    frame_tick = !reset && (hpos_q == '0) && (vpos_q == V_ACT);
  end

  // Delay line matching the BRAM read latency; reset flushes it to blank.
  always_ff @(posedge clk25M) begin
    if (reset) begin
      de_pipe_q   <= '0;
      bank_pipe_q <= '0;
      hs_pipe_q   <= '0;
      vs_pipe_q   <= '0;
    end else begin
      de_pipe_q[0]   <= active;
      bank_pipe_q[0] <= rd_bank;
      hs_pipe_q[0]   <= hs_act;
      vs_pipe_q[0]   <= vs_act;
      for (int i = 1; i < RD_LATENCY; i++) begin
        de_pipe_q[i]   <= de_pipe_q[i-1];
        bank_pipe_q[i] <= bank_pipe_q[i-1];
        hs_pipe_q[i]   <= hs_pipe_q[i-1];
        vs_pipe_q[i]   <= vs_pipe_q[i-1];
      end
    end
  end

  // Output register: pick the bank the data was read from, blank outside de.
  always_ff @(posedge clk25M) begin
    if (reset) begin
      rgb_q   <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~SYNC_ON;
      vsync_q <= ~SYNC_ON;
    end else begin
      de_q    <= de_pipe_q[RD_LATENCY-1];
      rgb_q   <= de_pipe_q[RD_LATENCY-1] ?
                 (bank_pipe_q[RD_LATENCY-1] ? rd_data_b : rd_data_a) : '0;
      hsync_q <= hs_pipe_q[RD_LATENCY-1] ? SYNC_ON : ~SYNC_ON;
      vsync_q <= vs_pipe_q[RD_LATENCY-1] ? SYNC_ON : ~SYNC_ON;
    end
  end

  assign rgb   = rgb_q;
  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_strip_scanner.sv
// Testbench for vga_strip_scanner: a default 640x480 instance plus a small
// instance (16 lines/strip, latency 2, active-high sync) so whole frames fit.
module tb_vga_strip_scanner;

  // ---------------- clock / reset ----------------
  logic clk25M = 1'b0;
  logic reset  = 1'b1;
  always #5 clk25M = ~clk25M;

  logic [11:0] rd_data_a = 12'hABC;
  logic [11:0] rd_data_b = 12'h123;

  // default instance
  logic [14:0] rd_addr, wr_addr;
  logic        rd_bank, wr_en, wr_bank, de, hsync, vsync, line_tick, frame_tick;
  logic [9:0]  wr_hpos, wr_vpos;
  logic [11:0] rgb;

  // small instance: H_TOTAL 24, V_TOTAL 80, frame 1920 cycles
  logic [7:0]  rd_addr_s, wr_addr_s;
  logic        rd_bank_s, wr_en_s, wr_bank_s, de_s, hsync_s, vsync_s, line_tick_s, frame_tick_s;
  logic [9:0]  wr_hpos_s, wr_vpos_s;
  logic [11:0] rgb_s;

  vga_strip_scanner dut (
    .clk25M(clk25M), .reset(reset),
    .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_hpos(wr_hpos), .wr_vpos(wr_vpos),
    .rgb(rgb), .de(de), .hsync(hsync), .vsync(vsync),
    .line_tick(line_tick), .frame_tick(frame_tick)
  );

  vga_strip_scanner #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(64), .V_FP(2), .V_SYNC(2), .V_BP(12),
    .STRIP_LINES(16), .PIX_W(12), .POS_W(10), .ADDR_W(8),
    .RD_LATENCY(2), .SYNC_POL(1)
  ) dut_s (
    .clk25M(clk25M), .reset(reset),
    .rd_addr(rd_addr_s), .rd_bank(rd_bank_s), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en_s), .wr_bank(wr_bank_s), .wr_addr(wr_addr_s), .wr_hpos(wr_hpos_s), .wr_vpos(wr_vpos_s),
    .rgb(rgb_s), .de(de_s), .hsync(hsync_s), .vsync(vsync_s),
    .line_tick(line_tick_s), .frame_tick(frame_tick_s)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;   // beam cycle index since the last reset release
  int base   = 0;   // start cycle of a small-instance frame

  // ---------------- driver tasks ----------------
  // Advance to beam cycle 'target'; signals are sampled 1 time unit after the edge.
  task automatic go_to(input int target);
    while (cyc < target) begin
      @(posedge clk25M);
      #1;
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Power-on reset held five cycles.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk25M);
      #1;
      n_cmp++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL rst_rgb: got %h exp 000", rgb); end
      n_cmp++; if (de !== 1'b0) begin n_fail++; $display("FAIL rst_de: got %b exp 0", de); end
      n_cmp++; if ({hsync, vsync} !== 2'b11) begin n_fail++; $display("FAIL rst_sync: got %b exp 11", {hsync, vsync}); end
      n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b exp 0", wr_en); end
      n_cmp++; if ({hsync_s, vsync_s} !== 2'b00) begin n_fail++; $display("FAIL rst_sync_s: got %b exp 00", {hsync_s, vsync_s}); end
    end
    reset = 1'b0;
    cyc   = 0;
    // Go into the middle of the hsync pulse, then reset mid-line.
    go_to(700);
    n_cmp++; if (hsync !== 1'b0) begin n_fail++; $display("FAIL pre_rst_hsync: got %b exp 0", hsync); end
    reset = 1'b1;
    #1;
    n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en_async_view: got %b exp 0", wr_en); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk25M);
      #1;
      n_cmp++; if (rgb !== 12'h000 || de !== 1'b0) begin n_fail++; $display("FAIL mrst_rgb_de: got %h/%b exp 000/0", rgb, de); end
      n_cmp++; if ({hsync, vsync} !== 2'b11) begin n_fail++; $display("FAIL mrst_sync: got %b exp 11", {hsync, vsync}); end
      n_cmp++; if (wr_en !== 1'b0 || rd_addr !== 15'd0 || wr_addr !== 15'd0) begin n_fail++; $display("FAIL mrst_addr: wr_en %b rd_addr %0d wr_addr %0d exp 0/0/0", wr_en, rd_addr, wr_addr); end
      n_cmp++; if (line_tick !== 1'b0 || frame_tick !== 1'b0) begin n_fail++; $display("FAIL mrst_ticks: got %b%b exp 00", line_tick, frame_tick); end
    end
    reset = 1'b0;
    cyc   = 0;
    #1;
    n_cmp++; if (rd_addr !== 15'd0) begin n_fail++; $display("FAIL first_rd_addr: got %0d exp 0", rd_addr); end
    n_cmp++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL first_wr_en: got %b exp 1", wr_en); end
    n_cmp++; if (wr_vpos !== 10'd32) begin n_fail++; $display("FAIL first_wr_vpos: got %0d exp 32", wr_vpos); end
    n_cmp++; if (wr_bank !== 1'b1 || rd_bank !== 1'b0) begin n_fail++; $display("FAIL first_banks: wr %b rd %b exp 1 0", wr_bank, rd_bank); end
  endtask

  task automatic test_data_path();
    go_to(1);
    n_cmp++; if (de !== 1'b0 || rgb !== 12'h000) begin n_fail++; $display("FAIL dp_cyc1: got %b/%h exp 0/000", de, rgb); end
    go_to(2);
    n_cmp++; if (de !== 1'b1) begin n_fail++; $display("FAIL dp_de_start: got %b exp 1", de); end
    n_cmp++; if (rgb !== 12'hABC) begin n_fail++; $display("FAIL dp_first_pix: got %h exp ABC", rgb); end
    go_to(641);
    n_cmp++; if (rgb !== 12'hABC) begin n_fail++; $display("FAIL dp_last_pix: got %h exp ABC", rgb); end
    go_to(642);
    n_cmp++; if (rgb !== 12'h000 || de !== 1'b0) begin n_fail++; $display("FAIL dp_hblank: got %h/%b exp 000/0", rgb, de); end
  endtask

  task automatic test_line_timing();
    go_to(657);
    n_cmp++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL hs_before: got %b exp 1", hsync); end
    go_to(658);
    n_cmp++; if (hsync !== 1'b0) begin n_fail++; $display("FAIL hs_fall: got %b exp 0", hsync); end
    go_to(753);
    n_cmp++; if (hsync !== 1'b0) begin n_fail++; $display("FAIL hs_last_low: got %b exp 0", hsync); end
    go_to(754);
    n_cmp++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL hs_rise: got %b exp 1", hsync); end
    go_to(1439);
    n_cmp++; if (line_tick !== 1'b0) begin n_fail++; $display("FAIL lt_before: got %b exp 0", line_tick); end
    go_to(1440);
    n_cmp++; if (line_tick !== 1'b1) begin n_fail++; $display("FAIL lt_at_640: got %b exp 1", line_tick); end
    go_to(1457);
    n_cmp++; if (hsync !== 1'b1) begin n_fail++; $display("FAIL hs2_before: got %b exp 1", hsync); end
    go_to(1458);
    n_cmp++; if (hsync !== 1'b0) begin n_fail++; $display("FAIL hs2_fall: got %b exp 0", hsync); end
  endtask

  task automatic test_bank_handover();
    go_to(24800);   // line 31, hpos 0
    n_cmp++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL ho_line31_bank: got %b exp 0", rd_bank); end
    go_to(25441);   // output of line 31, hpos 639
    n_cmp++; if (rgb !== 12'hABC) begin n_fail++; $display("FAIL ho_line31_rgb: got %h exp ABC", rgb); end
    go_to(25599);   // line 31, hpos 799
    n_cmp++; if (rd_bank !== 1'b0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL ho_blank: rd_bank %b wr_en %b exp 0 0", rd_bank, wr_en); end
    go_to(25600);   // line 32, hpos 0
    n_cmp++; if (rd_bank !== 1'b1 || wr_bank !== 1'b0) begin n_fail++; $display("FAIL ho_toggle: rd %b wr %b exp 1 0", rd_bank, wr_bank); end
    n_cmp++; if (wr_vpos !== 10'd64) begin n_fail++; $display("FAIL ho_wr_vpos: got %0d exp 64", wr_vpos); end
    go_to(25601);
    n_cmp++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL ho_gap: got %h exp 000", rgb); end
    go_to(25602);
    n_cmp++; if (rgb !== 12'h123) begin n_fail++; $display("FAIL ho_bank_b_rgb: got %h exp 123", rgb); end
  endtask

  task automatic test_addressing();
    go_to(33 * 800 + 5);   // vpos 33, hpos 5
    n_cmp++; if (rd_addr !== 15'd645) begin n_fail++; $display("FAIL addr_rd: got %0d exp 645", rd_addr); end
    n_cmp++; if (rd_bank !== 1'b1 || wr_bank !== 1'b0) begin n_fail++; $display("FAIL addr_banks: rd %b wr %b exp 1 0", rd_bank, wr_bank); end
    n_cmp++; if (wr_vpos !== 10'd65 || wr_hpos !== 10'd5) begin n_fail++; $display("FAIL addr_wr_pos: got %0d,%0d exp 5,65", wr_hpos, wr_vpos); end
    n_cmp++; if (wr_addr !== 15'd645 || wr_en !== 1'b1) begin n_fail++; $display("FAIL addr_wr: got %0d/%b exp 645/1", wr_addr, wr_en); end
  endtask

  // Small instance: bank period 16 lines, 3-cycle output delay, active-high sync,
  // write window and pre-render on a full frame.
  task automatic test_param_sweep();
    base = ((cyc / 1920) + 1) * 1920;
    go_to(base + 2);
    n_cmp++; if (de_s !== 1'b0) begin n_fail++; $display("FAIL ps_de_early: got %b exp 0", de_s); end
    go_to(base + 3);
    n_cmp++; if (de_s !== 1'b1 || rgb_s !== 12'hABC) begin n_fail++; $display("FAIL ps_first_pix: got %b/%h exp 1/ABC", de_s, rgb_s); end
    go_to(base + 18);
    n_cmp++; if (rgb_s !== 12'hABC) begin n_fail++; $display("FAIL ps_last_pix: got %h exp ABC", rgb_s); end
    go_to(base + 19);
    n_cmp++; if (rgb_s !== 12'h000 || de_s !== 1'b0) begin n_fail++; $display("FAIL ps_hblank: got %h/%b exp 000/0", rgb_s, de_s); end
    go_to(base + 20);
    n_cmp++; if (hsync_s !== 1'b0) begin n_fail++; $display("FAIL ps_hs_before: got %b exp 0", hsync_s); end
    go_to(base + 21);
    n_cmp++; if (hsync_s !== 1'b1) begin n_fail++; $display("FAIL ps_hs_rise: got %b exp 1", hsync_s); end
    go_to(base + 23);
    n_cmp++; if (hsync_s !== 1'b1) begin n_fail++; $display("FAIL ps_hs_last: got %b exp 1", hsync_s); end
    go_to(base + 24);
    n_cmp++; if (hsync_s !== 1'b0) begin n_fail++; $display("FAIL ps_hs_fall: got %b exp 0", hsync_s); end
    go_to(base + 15 * 24);
    n_cmp++; if (rd_bank_s !== 1'b0) begin n_fail++; $display("FAIL ps_bank_l15: got %b exp 0", rd_bank_s); end
    go_to(base + 16 * 24);
    n_cmp++; if (rd_bank_s !== 1'b1) begin n_fail++; $display("FAIL ps_bank_l16: got %b exp 1", rd_bank_s); end
    go_to(base + 16 * 24 + 3);
    n_cmp++; if (rgb_s !== 12'h123) begin n_fail++; $display("FAIL ps_bank_b_rgb: got %h exp 123", rgb_s); end
    go_to(base + 17 * 24 + 3);
    n_cmp++; if (rd_addr_s !== 8'd19) begin n_fail++; $display("FAIL ps_rd_addr: got %0d exp 19", rd_addr_s); end
    go_to(base + 32 * 24);
    n_cmp++; if (rd_bank_s !== 1'b0) begin n_fail++; $display("FAIL ps_bank_l32: got %b exp 0", rd_bank_s); end
    go_to(base + 47 * 24 + 15);
    n_cmp++; if (wr_en_s !== 1'b1 || wr_bank_s !== 1'b1) begin n_fail++; $display("FAIL ps_win_last: en %b bank %b exp 1 1", wr_en_s, wr_bank_s); end
    n_cmp++; if (wr_vpos_s !== 10'd63 || wr_addr_s !== 8'd255) begin n_fail++; $display("FAIL ps_win_last_pos: vpos %0d addr %0d exp 63 255", wr_vpos_s, wr_addr_s); end
    go_to(base + 48 * 24);
    n_cmp++; if (wr_en_s !== 1'b0 || rd_bank_s !== 1'b1) begin n_fail++; $display("FAIL ps_win_closed: en %b rd_bank %b exp 0 1", wr_en_s, rd_bank_s); end
    go_to(base + 63 * 24 + 15);
    n_cmp++; if (wr_en_s !== 1'b0) begin n_fail++; $display("FAIL ps_win_closed_l63: got %b exp 0", wr_en_s); end
    go_to(base + 64 * 24);
    n_cmp++; if (frame_tick_s !== 1'b1) begin n_fail++; $display("FAIL ps_frame_tick: got %b exp 1", frame_tick_s); end
    n_cmp++; if (wr_en_s !== 1'b1 || wr_bank_s !== 1'b0) begin n_fail++; $display("FAIL ps_pre_start: en %b bank %b exp 1 0", wr_en_s, wr_bank_s); end
    n_cmp++; if (wr_vpos_s !== 10'd0 || wr_addr_s !== 8'd0) begin n_fail++; $display("FAIL ps_pre_pos: vpos %0d addr %0d exp 0 0", wr_vpos_s, wr_addr_s); end
    go_to(base + 64 * 24 + 1);
    n_cmp++; if (frame_tick_s !== 1'b0) begin n_fail++; $display("FAIL ps_frame_tick_width: got %b exp 0", frame_tick_s); end
    go_to(base + 64 * 24 + 16);
    n_cmp++; if (wr_en_s !== 1'b0 || wr_addr_s !== 8'd0) begin n_fail++; $display("FAIL ps_pre_hblank: en %b addr %0d exp 0 0", wr_en_s, wr_addr_s); end
    go_to(base + 65 * 24 + 23 + 3);
    n_cmp++; if (vsync_s !== 1'b0) begin n_fail++; $display("FAIL ps_vs_before: got %b exp 0", vsync_s); end
    go_to(base + 66 * 24 + 3);
    n_cmp++; if (vsync_s !== 1'b1) begin n_fail++; $display("FAIL ps_vs_rise: got %b exp 1", vsync_s); end
    go_to(base + 67 * 24 + 23 + 3);
    n_cmp++; if (vsync_s !== 1'b1) begin n_fail++; $display("FAIL ps_vs_last: got %b exp 1", vsync_s); end
    go_to(base + 68 * 24 + 3);
    n_cmp++; if (vsync_s !== 1'b0) begin n_fail++; $display("FAIL ps_vs_fall: got %b exp 0", vsync_s); end
    go_to(base + 70 * 24);
    n_cmp++; if (rd_bank_s !== 1'b1) begin n_fail++; $display("FAIL ps_bank_hold: got %b exp 1", rd_bank_s); end
    go_to(base + 79 * 24 + 15);
    n_cmp++; if (wr_addr_s !== 8'd255 || wr_vpos_s !== 10'd15) begin n_fail++; $display("FAIL ps_pre_last: addr %0d vpos %0d exp 255 15", wr_addr_s, wr_vpos_s); end
  endtask

  // Whole-frame tallies on the small instance, plus one line of default hsync.
  task automatic test_frame_counts();
    int ft, lt, vs_hi, de_hi, we_hi, hs_lo;
    ft = 0; lt = 0; vs_hi = 0; de_hi = 0; we_hi = 0; hs_lo = 0;
    base = ((cyc / 1920) + 1) * 1920;
    go_to(base);
    for (int i = 0; i < 1920; i++) begin
      if (frame_tick_s === 1'b1) ft++;
      if (line_tick_s === 1'b1) lt++;
      if (vsync_s === 1'b1) vs_hi++;
      if (de_s === 1'b1) de_hi++;
      if (wr_en_s === 1'b1) we_hi++;
      if (i < 800 && hsync === 1'b0) hs_lo++;
      go_to(cyc + 1);
    end
    n_cmp++; if (ft != 1) begin n_fail++; $display("FAIL fc_frame_ticks: got %0d exp 1", ft); end
    n_cmp++; if (lt != 80) begin n_fail++; $display("FAIL fc_line_ticks: got %0d exp 80", lt); end
    n_cmp++; if (vs_hi != 48) begin n_fail++; $display("FAIL fc_vsync_cycles: got %0d exp 48", vs_hi); end
    n_cmp++; if (de_hi != 1024) begin n_fail++; $display("FAIL fc_de_cycles: got %0d exp 1024", de_hi); end
    n_cmp++; if (we_hi != 1024) begin n_fail++; $display("FAIL fc_wr_en_cycles: got %0d exp 1024", we_hi); end
    n_cmp++; if (hs_lo != 96) begin n_fail++; $display("FAIL fc_hsync_low: got %0d exp 96", hs_lo); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_data_path();
    test_line_timing();
    test_bank_handover();
    test_addressing();
    test_param_sweep();
    test_frame_counts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
